r4_sdf_stage: RTL and testbench
===============================

// Module: r4_sdf_stage
// PURPOSE
//   Parametrised radix-4 single-path delay-feedback (SDF) FFT stage. Accepts one complex
//   sample per valid cycle, buffers 3*DEPTH samples in three delay lines, runs a radix-4
//   butterfly on sample groups spaced DEPTH apart, and streams results out in order.
//   DEPTH=1 is a 4-point FFT; cascaded stages with DEPTH=N/4, N/16, ... 1 form an N-point pipeline.
// PARAMETERS
//   DW     16  sample component width (two's complement), input and output
//   DEPTH  1   delay-line length L (>=1); frame length is 4*L valid samples
//   SCALE  1   1: outputs = round(full/4); 0: outputs = full result saturated to DW
// PORTS
//   clk       in   1   clock, all state on rising edge
//   rst_n     in   1   asynchronous active-low reset
//   in_valid  in   1   input sample qualifier; low = stall, no state change
//   in_sof    in   1   start of frame, sampled only with in_valid
//   in_r      in   DW  input real
//   in_i      in   DW  input imag
//   out_valid out  1   output sample qualifier, registered
//   out_sof   out  1   marks first output (f0, idx 0) of a frame
//   out_r     out  DW  output real, registered
//   out_i     out  DW  output imag, registered
//   ovf       out  1   one-cycle pulse with an output sample that saturated (SCALE=0 only)
// BEHAVIOUR
// - Reset (async, rst_n=0): phase=0, idx=0, primed=0, out_valid=0, out_sof=0, ovf=0,
//   out_r=out_i=0. Delay-line contents are not cleared (may be RAM); garbage masked by primed.
// - Counters advance only on in_valid: idx 0..L-1, wrap to 0 and phase++ (2-bit, 3->0).
// - in_sof with in_valid: this sample is treated as phase 0, idx 0. If counters were not
//   already at (0,0), primed clears (pending outputs of interrupted frame are dropped).
// - Phase p in 0..2 (bypass): D_p[idx] <= input; output candidate = old D_p[idx].
// - Phase 3 (butterfly) on x0=D0[idx], x1=D1[idx], x2=D2[idx], x3=input, full width DW+2:
//     f0=x0+x1+x2+x3   f1=x0-jx1-x2+jx3   f2=x0-x1+x2-x3   f3=x0+jx1-x2-jx3
//   Output candidate = f0; D0[idx]<=f1, D1[idx]<=f2, D2[idx]<=f3 (stored already scaled to DW).
// - Scaling: SCALE=1 -> (v+2)>>>2 per component (round half up); SCALE=0 -> clamp to
//   [-2^(DW-1), 2^(DW-1)-1], ovf=1 if either component clamped. SCALE=1 never sets ovf.
// - primed sets on first phase-3 sample after reset/sof-realign; out_valid = in_valid && (phase==3
//   || primed), registered: outputs appear exactly 1 cycle after the accepting input.
// - Output order per frame: f0[0..L-1] (during its phase 3), then f1, f2, f3 blocks during the
//   next frame's phases 0..2. Latency first input -> first f0 = 3L valid samples + 1 cycle.
// - Last frame is drained by feeding a further 3L valid samples (e.g. zeros).
// - out_sof=1 with out_valid for phase 3, idx 0 output only.
// - in_valid=0: outputs keep value, out_valid=0, out_sof=0, ovf=0.
// TESTING
//   1. DW=16,L=1,SCALE=0: in (1,0),(2,0),(3,0),(4,0) then 4x(0,0) -> outputs (10,0)+sof,
//      (-2,2),(-2,0),(-2,-2); first out_valid 1 cycle after 4th input; nothing valid before.
//   2. SCALE=1,L=1: 4x(4000,0) then 4x zeros -> (4000,0),(0,0),(0,0),(0,0); ovf stays 0.
//   3. SCALE=0,L=1: 4x(16000,16000) -> f0=(32767,32767) with ovf=1 for that cycle only.
//   4. L=4,SCALE=0: impulse (1000,0) at sample 0, 15 zeros, 12 zeros drain -> 16 outputs
//      1000,0,0,0 repeated 4 times; out_sof on first.
//   5. Test 4 with random in_valid gaps -> identical output sequence, no out_valid during gaps.
//   6. rst_n low mid-frame, and separately in_sof at idx 2 of phase 1 -> no out_valid until
//      next phase 3; new frame then produces test-4 results exactly.

Source files
------------

// File: rtl/r4_sdf_stage.sv
// Radix-4 single-path delay-feedback FFT stage: three DEPTH-long delay lines feed a
// radix-4 butterfly every fourth block; one complex sample in and out per valid cycle.
module r4_sdf_stage #(
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 1,
    parameter int unsigned SCALE = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          in_sof,
    input  logic [DW-1:0] in_r,
    input  logic [DW-1:0] in_i,
    output logic          out_valid,
    output logic          out_sof,
    output logic [DW-1:0] out_r,
    output logic [DW-1:0] out_i,
    output logic          ovf
);
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned FW = DW + 2;
    localparam logic [IW-1:0] LastIdx = IW'(DEPTH - 1);
    localparam logic signed [FW-1:0] MaxV = {3'b000, {(DW-1){1'b1}}};
    localparam logic signed [FW-1:0] MinV = {3'b111, {(DW-1){1'b0}}};

    // Returns {clamped, value}; scaling rounds half up, otherwise saturates.
    function automatic logic [DW:0] scale_sat(input logic signed [FW-1:0] v);
        logic signed [FW:0] t;
        logic [DW:0]        res;
        t = {v[FW-1], v} + (FW+1)'(2);
        t = t >>> 2;
        if (SCALE != 0) begin
            res = {1'b0, t[DW-1:0]};
        end else if (v > MaxV) begin
            res = {1'b1, MaxV[DW-1:0]};
        end else if (v < MinV) begin
            res = {1'b1, MinV[DW-1:0]};
        end else begin
            res = {1'b0, v[DW-1:0]};
        end
        return res;
    endfunction

    logic [1:0]    phase_q, phase_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          primed_q, primed_d;
    logic          out_valid_q, out_sof_q, ovf_q;
    logic [DW-1:0] out_r_q, out_i_q;

    // Delay lines plus a per-entry flag remembering whether a stored result was clamped.
    logic [DW-1:0] dl_r   [3][DEPTH];
    logic [DW-1:0] dl_i   [3][DEPTH];
    logic          dl_ovf [3][DEPTH];

    logic [1:0]    eff_phase;
    logic [IW-1:0] eff_idx;
    logic          realign;
    logic          primed_eff;
    logic          out_valid_d;
    logic          out_sof_d;

    logic signed [FW-1:0] x_r [4];
    logic signed [FW-1:0] x_i [4];
    logic signed [FW-1:0] f_r [4];
    logic signed [FW-1:0] f_i [4];
    logic [DW:0]          sr_w [4];
    logic [DW:0]          si_w [4];
    logic [DW-1:0]        sc_r [4];
    logic [DW-1:0]        sc_i [4];
    logic                 sc_ov [4];

    logic [DW-1:0] cand_r, cand_i;
    logic          cand_ovf;

    // A start-of-frame forces this sample to (phase 0, idx 0).
    always_comb begin
        realign    = in_sof && ((phase_q != 2'd0) || (idx_q != '0));
        eff_phase  = in_sof ? 2'd0 : phase_q;
        eff_idx    = in_sof ? '0 : idx_q;
        primed_eff = primed_q && !realign;
    end

    always_comb begin
        phase_d  = phase_q;
        idx_d    = idx_q;
        primed_d = primed_q;
        if (in_valid) begin
            primed_d = primed_eff || (eff_phase == 2'd3);
            if (eff_idx == LastIdx) begin
                idx_d   = '0;
                phase_d = eff_phase + 2'd1;
            end else begin
                idx_d   = eff_idx + IW'(1);
                phase_d = eff_phase;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            x_r[k] = FW'($signed(dl_r[k][eff_idx]));
            x_i[k] = FW'($signed(dl_i[k][eff_idx]));
        end
        x_r[3] = FW'($signed(in_r));
        x_i[3] = FW'($signed(in_i));

        f_r[0] = x_r[0] + x_r[1] + x_r[2] + x_r[3];
        f_i[0] = x_i[0] + x_i[1] + x_i[2] + x_i[3];
        f_r[1] = x_r[0] + x_i[1] - x_r[2] - x_i[3];
        f_i[1] = x_i[0] - x_r[1] - x_i[2] + x_r[3];
        f_r[2] = x_r[0] - x_r[1] + x_r[2] - x_r[3];
        f_i[2] = x_i[0] - x_i[1] + x_i[2] - x_i[3];
        f_r[3] = x_r[0] - x_i[1] - x_r[2] + x_i[3];
        f_i[3] = x_i[0] + x_r[1] - x_i[2] - x_r[3];

        for (int k = 0; k < 4; k++) begin
            sr_w[k]  = scale_sat(f_r[k]);
            si_w[k]  = scale_sat(f_i[k]);
            sc_r[k]  = sr_w[k][DW-1:0];
            sc_i[k]  = si_w[k][DW-1:0];
            sc_ov[k] = sr_w[k][DW] | si_w[k][DW];
        end
    end

    always_comb begin
        cand_r   = '0;
        cand_i   = '0;
        cand_ovf = 1'b0;
        unique case (eff_phase)
            2'd0: begin
                cand_r   = dl_r[0][eff_idx];
                cand_i   = dl_i[0][eff_idx];
                cand_ovf = dl_ovf[0][eff_idx];
            end
            2'd1: begin
                cand_r   = dl_r[1][eff_idx];
                cand_i   = dl_i[1][eff_idx];
                cand_ovf = dl_ovf[1][eff_idx];
            end
            2'd2: begin
                cand_r   = dl_r[2][eff_idx];
                cand_i   = dl_i[2][eff_idx];
                cand_ovf = dl_ovf[2][eff_idx];
            end
            2'd3: begin
                cand_r   = sc_r[0];
                cand_i   = sc_i[0];
                cand_ovf = sc_ov[0];
            end
        endcase
    end

    always_comb begin
        out_valid_d = in_valid && ((eff_phase == 2'd3) || primed_eff);
        out_sof_d   = out_valid_d && (eff_phase == 2'd3) && (eff_idx == '0);
    end

    // Bypass phases store the raw input; the butterfly phase stores f1..f3 already scaled.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            for (int p = 0; p < 3; p++) begin
                if (eff_phase == 2'd3) begin
                    dl_r[p][eff_idx]   <= sc_r[p+1];
                    dl_i[p][eff_idx]   <= sc_i[p+1];
                    dl_ovf[p][eff_idx] <= sc_ov[p+1];
                end else if (eff_phase == 2'(p)) begin
                    dl_r[p][eff_idx]   <= in_r;
                    dl_i[p][eff_idx]   <= in_i;
                    dl_ovf[p][eff_idx] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q     <= 2'd0;
            idx_q       <= '0;
            primed_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            ovf_q       <= 1'b0;
            out_r_q     <= '0;
            out_i_q     <= '0;
        end else begin
            phase_q     <= phase_d;
            idx_q       <= idx_d;
            primed_q    <= primed_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
            ovf_q       <= out_valid_d && cand_ovf;
            if (out_valid_d) begin
                out_r_q <= cand_r;
                out_i_q <= cand_i;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign ovf       = ovf_q;
    assign out_r     = out_r_q;
    assign out_i     = out_i_q;

endmodule

// File: tb/tb_r4_sdf_stage.sv
// Bench for r4_sdf_stage: three instances (L=1 saturating, L=1 scaling, L=4 saturating) share
// one input stream and are checked against a frame-level DFT reference model.
module tb_r4_sdf_stage;
    localparam int DW = 16;

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic          sof;
        logic          ovf;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_sof = 1'b0;
    logic [DW-1:0] in_r = '0;
    logic [DW-1:0] in_i = '0;

    logic          ov_w [3];
    logic          os_w [3];
    logic [DW-1:0] or_w [3];
    logic [DW-1:0] oi_w [3];
    logic          of_w [3];

    int n_assert = 0;
    int n_fail = 0;

    int lv [3] = '{1, 1, 4};
    int sv [3] = '{0, 1, 0};
    int pos [3];
    bit prev_ok [3];
    int cur_r [3][16];
    int cur_i [3][16];
    int prev_r [3][16];
    int prev_i [3][16];
    ent_t lg0 [$];
    ent_t lg1 [$];
    ent_t lg2 [$];

    always #5 clk = ~clk;

    r4_sdf_stage #(.DW(DW), .DEPTH(1), .SCALE(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_r(in_r),
        .in_i(in_i), .out_valid(ov_w[0]), .out_sof(os_w[0]), .out_r(or_w[0]),
        .out_i(oi_w[0]), .ovf(of_w[0])
    );
    r4_sdf_stage #(.DW(DW), .DEPTH(1), .SCALE(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_r(in_r),
        .in_i(in_i), .out_valid(ov_w[1]), .out_sof(os_w[1]), .out_r(or_w[1]),
        .out_i(oi_w[1]), .ovf(of_w[1])
    );
    r4_sdf_stage #(.DW(DW), .DEPTH(4), .SCALE(0)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_r(in_r),
        .in_i(in_i), .out_valid(ov_w[2]), .out_sof(os_w[2]), .out_r(or_w[2]),
        .out_i(oi_w[2]), .ovf(of_w[2])
    );

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Bin m of the 4-point DFT over samples n, n+L, n+2L, n+3L of a frame.
    function automatic void dft(input int d, input bit use_prev, input int m, input int n,
                                output int re, output int im);
        re = 0;
        im = 0;
        for (int k = 0; k < 4; k++) begin
            int ar, ai;
            ar = use_prev ? prev_r[d][k*lv[d]+n] : cur_r[d][k*lv[d]+n];
            ai = use_prev ? prev_i[d][k*lv[d]+n] : cur_i[d][k*lv[d]+n];
            case ((m * k) % 4)
                0: begin re += ar; im += ai; end
                1: begin re += ai; im -= ar; end
                2: begin re -= ar; im -= ai; end
                default: begin re -= ai; im += ar; end
            endcase
        end
    endfunction

    function automatic int quant(input int v, input int scl, output bit sat);
        int q;
        sat = 1'b0;
        if (scl != 0) begin
            q = v + 2;
            return (q >= 0) ? q / 4 : -((-q + 3) / 4);
        end
        if (v > 32767) begin sat = 1'b1; return 32767; end
        if (v < -32768) begin sat = 1'b1; return -32768; end
        return v;
    endfunction

    task automatic step(input bit v, input bit s, input int r, input int i);
        in_valid = v;
        in_sof = s;
        in_r = r[DW-1:0];
        in_i = i[DW-1:0];
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            bit ev, es, eo, s1, s2;
            int p, fr, fi, er, ei;
            ev = 0; es = 0; eo = 0; er = 0; ei = 0; fr = 0; fi = 0;
            if (v) begin
                if (s) begin
                    if (pos[d] != 0) prev_ok[d] = 0;
                    pos[d] = 0;
                end
                p = pos[d];
                cur_r[d][p] = r;
                cur_i[d][p] = i;
                if (p >= 3 * lv[d]) begin
                    dft(d, 0, 0, p - 3 * lv[d], fr, fi);
                    ev = 1;
                    es = (p == 3 * lv[d]);
                end else if (prev_ok[d]) begin
                    dft(d, 1, p / lv[d] + 1, p % lv[d], fr, fi);
                    ev = 1;
                end
                if (ev) begin
                    er = quant(fr, sv[d], s1);
                    ei = quant(fi, sv[d], s2);
                    eo = s1 | s2;
                end
                pos[d]++;
                if (pos[d] == 4 * lv[d]) begin
                    pos[d] = 0;
                    prev_ok[d] = 1;
                    prev_r[d] = cur_r[d];
                    prev_i[d] = cur_i[d];
                end
            end
            check($sformatf("d%0d out_valid", d), 32'(ov_w[d]), 32'(ev));
            if (ev) begin
                check($sformatf("d%0d out_r", d), 32'($signed(or_w[d])), er);
                check($sformatf("d%0d out_i", d), 32'($signed(oi_w[d])), ei);
            end
            check($sformatf("d%0d out_sof", d), 32'(os_w[d]), 32'(es));
            check($sformatf("d%0d ovf", d), 32'(of_w[d]), 32'(eo));
            if (ov_w[d] === 1'b1) begin
                case (d)
                    0: lg0.push_back({or_w[d], oi_w[d], os_w[d], of_w[d]});
                    1: lg1.push_back({or_w[d], oi_w[d], os_w[d], of_w[d]});
                    default: lg2.push_back({or_w[d], oi_w[d], os_w[d], of_w[d]});
                endcase
            end
        end
    endtask

    task automatic do_reset();
        in_valid = 0;
        in_sof = 0;
        #2 rst_n = 0;
        #2;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst d%0d out_valid", d), 32'(ov_w[d]), 0);
            check($sformatf("rst d%0d out_sof", d), 32'(os_w[d]), 0);
            check($sformatf("rst d%0d ovf", d), 32'(of_w[d]), 0);
            check($sformatf("rst d%0d out_r", d), 32'($signed(or_w[d])), 0);
            check($sformatf("rst d%0d out_i", d), 32'($signed(oi_w[d])), 0);
            pos[d] = 0;
            prev_ok[d] = 0;
        end
        @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic clear_logs();
        lg0.delete();
        lg1.delete();
        lg2.delete();
    endtask

    function automatic int rnd16();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic run_impulse(input bit gaps);
        for (int k = 0; k < 28; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) step(0, 1'($urandom_range(0, 1)), rnd16(), rnd16());
            end
            step(1, k == 0, (k == 0) ? 1000 : 0, 0);
        end
    endtask

    task automatic check_impulse(input string tag);
        check({tag, " count"}, lg2.size(), 16);
        for (int k = 0; k < 16; k++) begin
            if (k < lg2.size()) begin
                check($sformatf("%s re[%0d]", tag, k), 32'($signed(lg2[k].re)),
                      (k % 4 == 0) ? 1000 : 0);
                check($sformatf("%s im[%0d]", tag, k), 32'($signed(lg2[k].im)), 0);
                check($sformatf("%s sof[%0d]", tag, k), 32'(lg2[k].sof), (k == 0) ? 1 : 0);
            end
        end
    endtask

    initial begin
        int t1r [4] = '{10, -2, -2, -2};
        int t1i [4] = '{0, 2, 0, -2};

        // Reset state
        do_reset();

        // Small 4-point frame, saturating L=1
        clear_logs();
        for (int k = 0; k < 4; k++) step(1, k == 0, k + 1, 0);
        for (int k = 0; k < 4; k++) step(1, 0, 0, 0);
        check("t1 count", lg0.size(), 5);
        for (int k = 0; k < 4; k++) begin
            if (k < lg0.size()) begin
                check($sformatf("t1 re[%0d]", k), 32'($signed(lg0[k].re)), t1r[k]);
                check($sformatf("t1 im[%0d]", k), 32'($signed(lg0[k].im)), t1i[k]);
                check($sformatf("t1 sof[%0d]", k), 32'(lg0[k].sof), (k == 0) ? 1 : 0);
            end
        end

        // Scaled DC frame
        do_reset();
        clear_logs();
        for (int k = 0; k < 4; k++) step(1, k == 0, 4000, 0);
        for (int k = 0; k < 4; k++) step(1, 0, 0, 0);
        check("t2 count", lg1.size(), 5);
        for (int k = 0; k < 4; k++) begin
            if (k < lg1.size()) begin
                check($sformatf("t2 re[%0d]", k), 32'($signed(lg1[k].re)), (k == 0) ? 4000 : 0);
                check($sformatf("t2 im[%0d]", k), 32'($signed(lg1[k].im)), 0);
                check($sformatf("t2 ovf[%0d]", k), 32'(lg1[k].ovf), 0);
            end
        end

        // Saturation on f0
        do_reset();
        clear_logs();
        for (int k = 0; k < 4; k++) step(1, k == 0, 16000, 16000);
        for (int k = 0; k < 4; k++) step(1, 0, 0, 0);
        check("t3 count", lg0.size(), 5);
        if (lg0.size() >= 2) begin
            check("t3 re", 32'($signed(lg0[0].re)), 32767);
            check("t3 im", 32'($signed(lg0[0].im)), 32767);
            check("t3 ovf", 32'(lg0[0].ovf), 1);
            check("t3 ovf next", 32'(lg0[1].ovf), 0);
        end

        // Impulse through L=4, then with valid gaps
        do_reset();
        clear_logs();
        run_impulse(0);
        check_impulse("t4");
        do_reset();
        clear_logs();
        run_impulse(1);
        check_impulse("t5");

        // Reset in the middle of a frame while outputs are flowing
        do_reset();
        for (int k = 0; k < 21; k++) step(1, k == 0, rnd16(), rnd16());
        do_reset();
        clear_logs();
        run_impulse(0);
        check_impulse("t6a");

        // Start-of-frame arriving at phase 1, idx 2
        do_reset();
        for (int k = 0; k < 22; k++) step(1, k == 0, rnd16(), rnd16());
        clear_logs();
        run_impulse(0);
        check_impulse("t6b");

        // Random soak: full-range data, random stalls and start-of-frame markers
        do_reset();
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, rnd16(), rnd16());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
